// File: rtl/fifo_read_arbiter_if.sv
// Read-port bundle between FIFO consumers/read-side controller and the arbiter.
// Pure wiring: no latency of its own.
// master drives requests and the empty flag; slave (the arbiter) drives strobe, grant and read-valid.
interface fifo_read_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] req_in;
    logic               r_empty_in;
    logic               r_request_out;
    logic [NUM_REQ-1:0] grant_out;
    logic               rd_valid_out;
    logic [ID_W-1:0]    rd_id_out;

    modport master (
        output req_in,
        output r_empty_in,
        input  r_request_out,
        input  grant_out,
        input  rd_valid_out,
        input  rd_id_out
    );

    modport slave (
        input  req_in,
        input  r_empty_in,
        output r_request_out,
        output grant_out,
        output rd_valid_out,
        output rd_id_out
    );
endinterface

// File: rtl/fifo_read_arbiter.sv
// Round-robin burst arbiter sharing one FIFO read port among NUM_REQ consumers.
// Latency: grant one cycle after request; rd_valid_out one cycle after each accepted read.
// Backpressure: r_empty_in or owner dropping its request stops the strobe the same cycle and ends the burst.
// Optional ARB_PERF_CNT_EN adds perf_reads_out, a saturating count of accepted reads.
module fifo_read_arbiter #(
    parameter int ADDR_WIDTH = 3,
    parameter int NUM_REQ    = 4,
    parameter int BURST_MAX  = 4
) (
    input  logic                r_clk_in,
    input  logic                r_reset_in,
    fifo_read_arbiter_if.slave  bus
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [15:0]         perf_reads_out
`endif
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] BURST_MAX_C = CNT_W'(BURST_MAX);
    localparam logic [ID_W-1:0]  LAST_RST    = ID_W'(NUM_REQ - 1);

    // ADDR_WIDTH is carried only so the parameter list matches the FIFO it sits beside.
    if (ADDR_WIDTH < 1) begin : g_addr_width_unused
    end

    typedef enum logic {IDLE, BURST} state_e;

    state_e           state_q, state_d;
    logic [ID_W-1:0]  owner_q, owner_d;
    logic [ID_W-1:0]  last_grant_q, last_grant_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic             rd_valid_q, rd_valid_d;
    logic [ID_W-1:0]  rd_id_q, rd_id_d;

    logic             found;
    logic [ID_W-1:0]  sel;
    logic             rd_req;

    // Round-robin search starting just above the previous owner, wrapping once.
    always_comb begin
        int              idx;
        logic [ID_W-1:0] cand;
        idx   = 0;
        cand  = '0;
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(last_grant_q) + 1 + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = ID_W'(idx);
            if (!found && bus.req_in[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    // Read strobe only while the owner still wants data, FIFO has data and burst budget remains.
    always_comb begin
        rd_req = (state_q == BURST) && bus.req_in[owner_q] && !bus.r_empty_in
                 && (burst_cnt_q < BURST_MAX_C);
    end

    // Next-state: grant from IDLE, count reads in BURST, always fall back to IDLE between owners.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        case (state_q)
            IDLE: begin
                if (found && !bus.r_empty_in) begin
                    state_d      = BURST;
                    owner_d      = sel;
                    last_grant_d = sel;
                    burst_cnt_d  = '0;
                end
            end
            BURST: begin
                if (rd_req) begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                end
                if (!bus.req_in[owner_q] || bus.r_empty_in
                    || (rd_req && (burst_cnt_d == BURST_MAX_C))) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        rd_valid_d = rd_req;
        rd_id_d    = owner_q;
    end

    // All arbiter state and the registered read-valid outputs.
    always_ff @(posedge r_clk_in) begin
        if (r_reset_in) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_grant_q <= LAST_RST;
            burst_cnt_q  <= '0;
            rd_valid_q   <= 1'b0;
            rd_id_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
            rd_valid_q   <= rd_valid_d;
            rd_id_q      <= rd_id_d;
        end
    end

    assign bus.r_request_out = rd_req;
    assign bus.grant_out     = (state_q == BURST) ? (NUM_REQ'(1) << owner_q) : '0;
    assign bus.rd_valid_out  = rd_valid_q;
    assign bus.rd_id_out     = rd_id_q;

`ifdef ARB_PERF_CNT_EN
    logic [15:0] perf_q, perf_d;

    // Accepted-read counter, sticks at all-ones.
    always_comb begin
        perf_d = perf_q;
        if (rd_req && (perf_q != 16'hFFFF)) begin
            perf_d = perf_q + 16'd1;
        end
    end

    // Performance counter register.
    always_ff @(posedge r_clk_in) begin
        if (r_reset_in) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_reads_out = perf_q;
`endif

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Directed bench for fifo_read_arbiter (NUM_REQ=4, BURST_MAX=4).
// Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
// Vector table covers reset, bursts, empty/drop backpressure and reset abort; loops cover rotation.
module tb_fifo_read_arbiter;

    logic r_clk;
    logic r_rst;
    int   tests;
    int   fails;

    fifo_read_arbiter_if #(.NUM_REQ(4)) bus ();

`ifdef ARB_PERF_CNT_EN
    logic [15:0] perf_reads;
`endif

    fifo_read_arbiter #(
        .ADDR_WIDTH (3),
        .NUM_REQ    (4),
        .BURST_MAX  (4)
    ) dut (
        .r_clk_in   (r_clk),
        .r_reset_in (r_rst),
        .bus        (bus.slave)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_reads_out (perf_reads)
`endif
    );

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       emp;
        logic       chk;
        logic       exp_rq;
        logic [3:0] exp_gnt;
        logic       exp_vld;
        logic [1:0] exp_id;
    } vec_t;

    vec_t vecs [23];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic rq, input logic [3:0] gnt,
                              input logic vld, input logic [1:0] id, input logic chk_id);
        check({tag, "_req"},   32'(bus.r_request_out), 32'(rq));
        check({tag, "_gnt"},   32'(bus.grant_out),     32'(gnt));
        check({tag, "_vld"},   32'(bus.rd_valid_out),  32'(vld));
        if (chk_id) begin
            check({tag, "_id"}, 32'(bus.rd_id_out),    32'(id));
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        r_rst = 1'b1;
        bus.req_in     = 4'b0000;
        bus.r_empty_in = 1'b0;

        //           rst req      emp chk rq  gnt      vld id
        vecs[0]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
        vecs[1]  = '{1'b1, 4'b0001, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0};
        vecs[2]  = '{1'b0, 4'b0001, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0};
        vecs[3]  = '{1'b0, 4'b0001, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b0, 2'd0};
        vecs[4]  = '{1'b0, 4'b0001, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd0};
        vecs[5]  = '{1'b0, 4'b0001, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd0};
        vecs[6]  = '{1'b0, 4'b0001, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd0};
        vecs[7]  = '{1'b0, 4'b0001, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd0};
        vecs[8]  = '{1'b0, 4'b0001, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b0, 2'd0};
        vecs[9]  = '{1'b0, 4'b0100, 1'b0, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0};
        vecs[10] = '{1'b0, 4'b0100, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0};
        vecs[11] = '{1'b0, 4'b0100, 1'b0, 1'b1, 1'b1, 4'b0100, 1'b0, 2'd0};
        vecs[12] = '{1'b0, 4'b0100, 1'b0, 1'b1, 1'b1, 4'b0100, 1'b1, 2'd2};
        vecs[13] = '{1'b0, 4'b0100, 1'b1, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd2};
        vecs[14] = '{1'b0, 4'b0100, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd2};
        vecs[15] = '{1'b0, 4'b0010, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd2};
        vecs[16] = '{1'b0, 4'b0010, 1'b0, 1'b1, 1'b1, 4'b0010, 1'b0, 2'd2};
        vecs[17] = '{1'b0, 4'b1101, 1'b0, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1};
        vecs[18] = '{1'b0, 4'b1101, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd1};
        vecs[19] = '{1'b0, 4'b1101, 1'b0, 1'b1, 1'b1, 4'b0100, 1'b0, 2'd1};
        vecs[20] = '{1'b1, 4'b1101, 1'b0, 1'b1, 1'b1, 4'b0100, 1'b1, 2'd2};
        vecs[21] = '{1'b0, 4'b1101, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0};
        vecs[22] = '{1'b0, 4'b1101, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b0, 2'd0};

        // Table: one vector per clock cycle.
        for (int k = 0; k < 23; k++) begin
            if (k != 0) begin
                @(posedge r_clk);
                #1;
            end
            r_rst          = vecs[k].rst;
            bus.req_in     = vecs[k].req;
            bus.r_empty_in = vecs[k].emp;
            @(negedge r_clk);
            if (vecs[k].chk) begin
                check_outs($sformatf("vec%0d", k), vecs[k].exp_rq, vecs[k].exp_gnt,
                           vecs[k].exp_vld, vecs[k].exp_id, 1'b1);
            end
        end

        // Rotation with all four requesting: grants 0,1,2,3,0, four reads each, one idle between.
        @(posedge r_clk);
        #1;
        r_rst = 1'b1;
        @(posedge r_clk);
        #1;
        r_rst          = 1'b0;
        bus.req_in     = 4'b1111;
        bus.r_empty_in = 1'b0;
        @(negedge r_clk);
        check_outs("rot_idle_first", 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1);
        for (int g = 0; g < 5; g++) begin
            logic [1:0] exp_own;
            logic [3:0] exp_gnt;
            exp_own = 2'(g % 4);
            exp_gnt = 4'b0001 << exp_own;
            for (int b = 0; b < 4; b++) begin
                @(posedge r_clk);
                @(negedge r_clk);
                check_outs($sformatf("rot_g%0d_b%0d", g, b), 1'b1, exp_gnt,
                           (b > 0), exp_own, (b > 0));
            end
            @(posedge r_clk);
            @(negedge r_clk);
            check_outs($sformatf("rot_g%0d_idle", g), 1'b0, 4'b0000, 1'b1, exp_own, 1'b1);
        end

`ifdef ARB_PERF_CNT_EN
        begin
            int seen;
            seen = 0;
            @(posedge r_clk);
            #1;
            r_rst = 1'b1;
            @(posedge r_clk);
            #1;
            r_rst      = 1'b0;
            bus.req_in = 4'b0001;
            @(negedge r_clk);
            check("perf_after_reset", 32'(perf_reads), 32'd0);
            for (int c = 0; c < 200 && seen < 10; c++) begin
                if (c != 0) @(negedge r_clk);
                if (bus.r_request_out) seen++;
            end
            check("perf_reads_seen", 32'(seen), 32'd10);
            @(posedge r_clk);
            #1;
            bus.req_in = 4'b0000;
            @(negedge r_clk);
            check("perf_count_10", 32'(perf_reads), 32'd10);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
